// File: rtl/serial_mac_pe_if.sv
//----------------------------------------------------------------------------
// Module   : serial_mac_pe_if
// Brief    : Operand-stream / result bundle between the PE sequencer and MAC.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface serial_mac_pe_if #(
  parameter int DW = 16,
  parameter int OW = 32
);
  logic signed [DW-1:0] neuron;
  logic signed [DW-1:0] weight;
  logic [1:0]           ctl;
  logic                 vld_i;
  logic [OW-1:0]        result;
  logic                 vld_o;
  logic                 ovf;

  modport master (
    output neuron, weight, ctl, vld_i,
    input  result, vld_o, ovf
  );

  modport slave (
    input  neuron, weight, ctl, vld_i,
    output result, vld_o, ovf
  );
endinterface

`default_nettype wire

// File: rtl/serial_mac_pe.sv
//----------------------------------------------------------------------------
// Module   : serial_mac_pe
// Brief    : 3-stage serial signed MAC; one dot-product result per vector.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module serial_mac_pe #(
  parameter int DW   = 16,
  parameter int ACCW = 45,
  parameter int OW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  serial_mac_pe_if.slave  bus
);

  localparam int c_PW = 2 * DW;

  // S1: registered operands and markers
  logic                 r_s1_v;
  logic                 r_s1_first;
  logic                 r_s1_last;
  logic signed [DW-1:0] r_s1_neuron;
  logic signed [DW-1:0] r_s1_weight;

  // S2: sign-extended product
  logic                 r_s2_v;
  logic                 r_s2_first;
  logic                 r_s2_last;
  logic [ACCW-1:0]      r_s2_prod;

  // S3: accumulator and registered outputs
  logic [ACCW-1:0]      r_acc;
  logic [OW-1:0]        r_result;
  logic                 r_vld_o;
  logic                 r_ovf;

  logic signed [c_PW-1:0] w_n_ext;
  logic signed [c_PW-1:0] w_w_ext;
  logic signed [c_PW-1:0] w_prod;
  logic [ACCW-1:0]        w_sum;
  logic [ACCW-OW:0]       w_hi;
  logic                   w_ovf;

  // Operands widened first so the low 2*DW bits hold the exact signed product.
  assign w_n_ext = {{DW{r_s1_neuron[DW-1]}}, r_s1_neuron};
  assign w_w_ext = {{DW{r_s1_weight[DW-1]}}, r_s1_weight};
  assign w_prod  = w_n_ext * w_w_ext;

  assign w_sum = r_s2_first ? r_s2_prod : r_acc + r_s2_prod;
  assign w_hi  = w_sum[ACCW-1:OW-1];
  assign w_ovf = ~((&w_hi) | (~|w_hi));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v      <= 1'b0;
      r_s1_first  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_neuron <= '0;
      r_s1_weight <= '0;
      r_s2_v      <= 1'b0;
      r_s2_first  <= 1'b0;
      r_s2_last   <= 1'b0;
      r_s2_prod   <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_vld_o     <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      // Markers are gated by the beat valid so idle-cycle ctl never leaks in.
      r_s1_v     <= bus.vld_i;
      r_s1_first <= bus.vld_i & bus.ctl[0];
      r_s1_last  <= bus.vld_i & bus.ctl[1];
      if (bus.vld_i) begin
        r_s1_neuron <= bus.neuron;
        r_s1_weight <= bus.weight;
      end

      r_s2_v     <= r_s1_v;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
      if (r_s1_v) begin
        r_s2_prod <= {{(ACCW-c_PW){w_prod[c_PW-1]}}, w_prod};
      end

      if (r_s2_v) begin
        r_acc <= w_sum;
      end

      r_vld_o <= r_s2_v & r_s2_last;
      if (r_s2_v && r_s2_last) begin
        r_result <= w_sum[OW-1:0];
        r_ovf    <= w_ovf;
      end
    end
  end

  assign bus.result = r_result;
  assign bus.vld_o  = r_vld_o;
  assign bus.ovf    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_mac_pe.sv
//----------------------------------------------------------------------------
// Module   : tb_serial_mac_pe
// Brief    : Self-checking bench for serial_mac_pe against an arithmetic model.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_serial_mac_pe;

  logic clk;
  logic rst;

  serial_mac_pe_if #(.DW(16), .OW(32)) bus ();

  serial_mac_pe #(.DW(16), .ACCW(45), .OW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  logic [44:0] m_acc;
  int          cyc;
  int          n_asserts;
  int          n_fail;
  int          n_strobes;
  logic [31:0] last_res;
  logic        last_ovf;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_asserts++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Checks the outputs right after edge 'cyc' against the expectation queue.
  task automatic check_cycle();
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("strobe", 64'(bus.vld_o), 64'(1'b1));
      chk("result", 64'(bus.result), 64'(e.res));
      chk("ovf", 64'(bus.ovf), 64'(e.ovf));
    end else begin
      chk("no_strobe", 64'(bus.vld_o), 64'(1'b0));
    end
    if (bus.vld_o === 1'b1) begin
      n_strobes++;
      last_res = bus.result;
      last_ovf = bus.ovf;
    end
  endtask

  task automatic beat(input logic [15:0] n, input logic [15:0] w,
                      input logic [1:0] c, input logic v);
    logic signed [15:0] sn;
    logic signed [15:0] sw;
    logic signed [44:0] ss;
    longint             p;
    longint             s;
    exp_t               e;
    @(negedge clk);
    bus.neuron = n;
    bus.weight = w;
    bus.ctl    = c;
    bus.vld_i  = v;
    @(posedge clk);
    cyc++;
    if (v) begin
      sn = n;
      sw = w;
      p  = longint'(sn) * longint'(sw);
      m_acc = c[0] ? p[44:0] : m_acc + p[44:0];
      if (c[1]) begin
        ss    = m_acc;
        s     = ss;
        e.due = cyc + 2;
        e.res = m_acc[31:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        exp_q.push_back(e);
      end
    end
    #1;
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(16'h0, 16'h0, 2'b00, 1'b0);
  endtask

  task automatic vec_const(input logic [15:0] n, input logic [15:0] w, input int len);
    for (int i = 0; i < len; i++)
      beat(n, w, {(i == len - 1), (i == 0)}, 1'b1);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst       = 1'b1;
    bus.vld_i = 1'b0;
    #1;
    chk("rst_async_result", 64'(bus.result), 64'h0);
    chk("rst_async_vld", 64'(bus.vld_o), 64'h0);
    chk("rst_async_ovf", 64'(bus.ovf), 64'h0);
    exp_q.delete();
    m_acc = '0;
    @(posedge clk);
    cyc++;
    #1;
    chk("rst_hold_vld", 64'(bus.vld_o), 64'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int s0;

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    n_strobes = 0;
    cyc       = 0;
    m_acc     = '0;
    last_res  = '0;
    last_ovf  = 1'b0;
    bus.neuron = '0;
    bus.weight = '0;
    bus.ctl    = '0;
    bus.vld_i  = 1'b0;
    rst        = 1'b1;

    // Reset state
    @(posedge clk);
    #1;
    chk("reset_result", 64'(bus.result), 64'h0);
    chk("reset_vld_o", 64'(bus.vld_o), 64'h0);
    chk("reset_ovf", 64'(bus.ovf), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // 32 beats of 1*2
    s0 = n_strobes;
    vec_const(16'h0001, 16'h0002, 32);
    idle(4);
    chk("s1_count", 64'(n_strobes - s0), 64'd1);
    chk("s1_result", 64'(last_res), 64'h40);
    chk("s1_ovf", 64'(last_ovf), 64'h0);

    // -3*5 x4 then a back-to-back single-beat full-scale positive square
    s0 = n_strobes;
    vec_const(16'hFFFD, 16'h0005, 4);
    beat(16'h7FFF, 16'h7FFF, 2'b11, 1'b1);
    idle(4);
    chk("s2_count", 64'(n_strobes - s0), 64'd2);
    chk("s2_result", 64'(last_res), 64'h3FFF0001);

    // 4 * 0x8000^2 = 2^32 overflows; then 1*1 single beat
    vec_const(16'h8000, 16'h8000, 4);
    idle(3);
    chk("s3_result", 64'(last_res), 64'h0);
    chk("s3_ovf", 64'(last_ovf), 64'h1);
    beat(16'h0001, 16'h0001, 2'b11, 1'b1);
    idle(3);
    chk("s3b_result", 64'(last_res), 64'h1);
    chk("s3b_ovf", 64'(last_ovf), 64'h0);

    // Bubbles with toggling ctl while invalid
    s0 = n_strobes;
    for (int i = 0; i < 32; i++) begin
      while ($urandom_range(0, 2) == 0)
        beat(16'($urandom), 16'($urandom), 2'($urandom), 1'b0);
      beat(16'h0001, 16'h0002, {(i == 31), (i == 0)}, 1'b1);
    end
    idle(4);
    chk("s4_count", 64'(n_strobes - s0), 64'd1);
    chk("s4_result", 64'(last_res), 64'h40);

    // Four random 32-beat vectors back to back
    s0 = n_strobes;
    for (int v = 0; v < 4; v++)
      for (int i = 0; i < 32; i++)
        beat(16'($urandom), 16'($urandom), {(i == 31), (i == 0)}, 1'b1);
    idle(4);
    chk("s5_count", 64'(n_strobes - s0), 64'd4);

    // Mid-vector reset, then a full random vector
    s0 = n_strobes;
    for (int i = 0; i < 20; i++)
      beat(16'($urandom), 16'($urandom), {1'b0, (i == 0)}, 1'b1);
    rst_pulse();
    idle(5);
    chk("s6_aborted", 64'(n_strobes - s0), 64'd0);
    for (int i = 0; i < 32; i++)
      beat(16'($urandom), 16'($urandom), {(i == 31), (i == 0)}, 1'b1);
    idle(4);
    chk("s6_count", 64'(n_strobes - s0), 64'd1);

    // Last without first since reset, and a first restart mid-vector
    rst_pulse();
    idle(1);
    s0 = n_strobes;
    beat(16'h0003, 16'h0004, 2'b00, 1'b1);
    beat(16'h0002, 16'h0002, 2'b10, 1'b1);
    beat(16'h0005, 16'h0005, 2'b01, 1'b1);
    beat(16'h0007, 16'h0007, 2'b01, 1'b1);
    beat(16'h0001, 16'h0001, 2'b10, 1'b1);
    idle(4);
    chk("s7_count", 64'(n_strobes - s0), 64'd2);
    chk("s7_result", 64'(last_res), 64'd50);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_mac_pe.md
# serial_mac_pe

Serial multiply-accumulate processing element: the consumer end of the operand-stream interface produced by the PE stimulus/sequencer logic. It takes one signed 16-bit neuron/weight pair per valid beat. Vector boundaries are marked by `ctl[0]` (first) and `ctl[1]` (last). It emits one 32-bit dot-product result per vector with a single-cycle `vld_o` strobe. It sits behind the operand fetch path and feeds the result check/writeback stage.

## Interface
- `DW`, 16, operand width (neuron and weight), two's complement.
- `ACCW`, 45, internal accumulator width. Covers 8192 full-scale products without wrap.
- `OW`, 32, result width. The result is the accumulator truncated to its low `OW` bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `neuron`  in  DW  signed operand; sampled only when `vld_i`=1.
- `weight`  in  DW  signed operand; sampled only when `vld_i`=1.
- `ctl`  in  2  `[0]` first beat of vector, `[1]` last beat of vector; both may be 1 together. Ignored when `vld_i`=0.
- `vld_i`  in  1  beat valid; no backpressure, so every valid beat is consumed.
- `result`  out  OW  signed dot product, low `OW` bits of the accumulator.
- `vld_o`  out  1  one-cycle strobe; `result`/`ovf` are valid while it is high.
- `ovf`  out  1  accumulator value not representable in `OW`-bit signed. Qualified by `vld_o`.

## Operation
- 3-stage pipeline; each stage carries `v`, `first`, `last` along with its data.
  - S1: register `neuron`, `weight`, `ctl`, `vld_i`.
  - S2: signed product, 2·DW = 32 bits, sign-extended to ACCW.
  - S3: accumulate.
- Accumulate rule, applied when the S2 stage is valid:
  - `first`=1: `acc <= product` (prior contents discarded).
  - otherwise: `acc <= acc + product`, wrapping modulo 2^ACCW.
- If S2 is not valid, `acc` holds its value. Bubbles (`vld_i`=0) between beats of one vector are legal and do not change the result.
- Result capture happens when the S2 stage has `last`=1:
  - `result <= (first ? product : acc + product)[OW-1:0]`.
  - `ovf <=` 1 if bits `[ACCW-1:OW-1]` of that same sum are not all equal.
  - `vld_o <= 1`.
- In every other cycle `vld_o <= 0`; `result` and `ovf` hold their last value.
- Single-beat vector (`ctl`=2'b11): result equals the product alone.
- `last` with no preceding `first` since reset: accumulates from the reset value of `acc` (0).
- `first` in the middle of an open vector: restarts accumulation; the partial sum is discarded and no output is produced.
- Back-to-back vectors: `last` of vector N and `first` of vector N+1 on consecutive beats, with no gap required. Full throughput is one beat per cycle.
- Width rules:
  - Product: full-precision signed DW×DW, no rounding.
  - No saturation anywhere. Truncation to OW bits is the only narrowing.

## Timing
- Reset values: `result`=0, `vld_o`=0, `ovf`=0. All pipeline valids, `acc`, and S1/S2 data registers are 0.
- Latency: a beat with `vld_i`=1 and `ctl[1]`=1 sampled at edge T asserts `vld_o` during the cycle following edge T+2. That is 3 cycles from input to strobe, independent of vector length.
- `vld_o` is high for exactly one cycle per `last` beat. Two single-beat vectors on consecutive cycles give `vld_o` high on two consecutive cycles.
- Reset asserted mid-vector: all state clears immediately. In-flight beats are dropped and no `vld_o` fires for them. The first valid beat after release is processed normally.
- Outputs are driven from registers only; there is no combinational path from inputs to outputs.

## Test plan
- Vector of 32 beats, neuron=0x0001, weight=0x0002, `ctl[0]` on beat 0, `ctl[1]` on beat 31 -> one `vld_o` 3 cycles after beat 31; `result`=0x00000040, `ovf`=0.
- 4 beats, neuron=0xFFFD (−3), weight=0x0005 -> `result`=0xFFFFFFC4 (−60), `ovf`=0. Then a single beat 0x7FFF×0x7FFF with `ctl`=2'b11 on the very next cycle -> second strobe one cycle later with `result`=0x3FFF0001.
- 4 beats of 0x8000×0x8000 -> `result`=0x00000000, `ovf`=1. The next vector of 1×1 single beat -> `result`=0x00000001, `ovf`=0.
- Same 32-beat vector as the first scenario with `vld_i` randomly deasserted; `ctl` toggled while `vld_i`=0 -> `result`=0x00000040, one strobe only, 3 cycles after the last valid beat.
- Four 32-beat vectors back to back, each beat's operand pair drawn from random signed stimulus -> four strobes spaced 32 cycles apart, each matching the reference model's 45-bit sum truncated to 32 bits.
- Assert `rst` for 1 cycle at beat 20 of a 32-beat vector, then restart a full vector -> no strobe for the aborted vector; the restarted vector returns the correct value; all outputs are 0 during reset.
